// File: rtl/rca_pipe_nbits.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready stream interface.
// The BITS-wide add is cut into STAGES ripple segments of SEG bits. Each stage
// resolves one segment using the carry registered by the previous stage, while
// the not-yet-added upper operand bits ride along in shrinking skew registers.
// A single global enable advances the whole pipe. Bubbles are kept, not collapsed.
module rca_pipe_nbits #(
  parameter int BITS   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] s,
  output logic            co,
  output logic            ovf
);

  localparam int SEG = BITS / STAGES;

  if (STAGES < 1 || (BITS % STAGES) != 0) begin : g_param_check
    $error("rca_pipe_nbits: STAGES must be >= 1 and divide BITS");
  end

  // Subtraction is a + ~b + 1: invert b and force the carry-in up front.
  logic [BITS-1:0] b_eff;
  logic            c0;
  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : ci;

  // The pipe moves only when the output slot is empty or being drained.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits still unresolved when entering this stage (segment k and up).
    localparam int IW = BITS - k * SEG;

    logic [IW-1:0]         op_a_in;
    logic [IW-1:0]         op_b_in;
    logic                  c_in;
    logic                  v_in;
    logic [(k+1)*SEG-1:0]  sum_next;
    logic [SEG:0]          seg_sum;

    logic [(k+1)*SEG-1:0]  sum_q;
    logic                  carry_q;
    logic                  valid_q;

    // Ripple add of this stage's segment; carry leaves only through carry_q.
    assign seg_sum = {1'b0, op_a_in[SEG-1:0]} + {1'b0, op_b_in[SEG-1:0]}
                   + {{SEG{1'b0}}, c_in};

    if (k == 0) begin : g_first
      assign op_a_in  = a;
      assign op_b_in  = b_eff;
      assign c_in     = c0;
      assign v_in     = in_valid;
      assign sum_next = seg_sum[SEG-1:0];
    end else begin : g_next
      assign op_a_in  = g_stage[k-1].g_fwd.op_a_q;
      assign op_b_in  = g_stage[k-1].g_fwd.op_b_q;
      assign c_in     = g_stage[k-1].carry_q;
      assign v_in     = g_stage[k-1].valid_q;
      assign sum_next = {seg_sum[SEG-1:0], g_stage[k-1].sum_q};
    end

    // Stage register: resolved low sum bits, segment carry-out and valid bit.
    // NOTE: the reset is in the sensitivity list, so it acts without a clock edge;
    // every state update uses <= so all stages sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
        valid_q <= 1'b0;
      end else if (en) begin
        sum_q   <= sum_next;
        carry_q <= seg_sum[SEG];
        valid_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-SEG-1:0] op_a_q;
      logic [IW-SEG-1:0] op_b_q;

      // Skew registers: carry the upper operand bits forward to later stages.
      // NOTE: these datapath registers are reset too, so no stale operand
      // from before a reset can ever be observed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          op_a_q <= '0;
          op_b_q <= '0;
        end else if (en) begin
          op_a_q <= op_a_in[IW-1:SEG];
          op_b_q <= op_b_in[IW-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_q;
      logic c_msb;

      // Carry into the MSB, recovered from the MSB sum bit of this segment.
      assign c_msb = op_a_in[SEG-1] ^ op_b_in[SEG-1] ^ seg_sum[SEG-1];

      // Overflow flag registered alongside the final segment.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c_msb ^ seg_sum[SEG];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign co        = g_stage[STAGES-1].carry_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: doc/rca_pipe_nbits.md
RCA_PIPE_NBITS -- requirements
Module: rca_pipe_nbits

Interface
REQ-001 SHALL provide parameter BITS, default 32, total operand width.
REQ-002 SHALL provide parameter STAGES, default 4, pipeline segment count; legal iff STAGES >= 1 and BITS % STAGES == 0; SEG = BITS/STAGES.
REQ-003 SHALL use a single clock and an asynchronous active-high reset; ports clk and rst.
REQ-004 SHALL provide the following ports (name direction width meaning):
  clk        in   1     rising-edge clock
  rst        in   1     async active-high reset
  in_valid   in   1     operand beat offered
  in_ready   out  1     beat accepted when in_valid & in_ready
  a          in   BITS  operand A
  b          in   BITS  operand B
  ci         in   1     carry in (add mode only)
  sub        in   1     0: a+b+ci, 1: a-b
  out_valid  out  1     result beat present
  out_ready  in   1     consumer accepts when out_valid & out_ready
  s          out  BITS  sum/difference
  co         out  1     carry out (sub: 1 = no borrow)
  ovf        out  1     two's-complement overflow

Function
REQ-005 SHALL compute, for an accepted beat, {co,s} = a + b + ci when sub=0, and {co,s} = a + ~b + 1 when sub=1 (ci ignored).
REQ-006 SHALL set ovf = carry into bit BITS-1 XOR co for the same beat.
REQ-007 SHALL split the adder into STAGES ripple segments of SEG bits; segment k resolves bits [k*SEG+SEG-1 : k*SEG] in pipeline stage k using the carry registered from stage k-1.
REQ-008 SHALL skew operands so that unresolved upper segments of a, b (after sub inversion) travel in per-stage registers alongside resolved lower sum bits; no combinational carry path crosses a stage register.
REQ-009 SHALL hold a valid bit per stage; the output register is stage STAGES-1.
REQ-010 SHALL use a global advance enable en = !out_valid | out_ready; all stage registers and valid bits load only when en = 1, otherwise hold.
REQ-011 SHALL drive in_ready = en combinationally; in_ready does not depend on in_valid.
REQ-012 SHALL load stage-0 valid with in_valid & en; stage k valid loads stage k-1 valid when en.
REQ-013 SHALL produce each result exactly STAGES cycles after acceptance when out_ready is held 1; throughput one beat per cycle.
REQ-014 SHALL, when out_valid=1 and out_ready=0, hold s, co, ovf, out_valid stable and deassert in_ready until the beat is accepted.
REQ-015 SHALL preserve order; no beat duplicated or dropped under any in_valid/out_ready pattern.
REQ-016 SHALL pass bubbles (invalid stages) through the pipe; bubbles are not collapsed.
REQ-017 SHALL, when STAGES = 1, degenerate to a single registered full-width adder with latency 1.
REQ-018 SHALL accept a new beat in the same cycle the output beat is consumed (simultaneous in and out handshake).
REQ-019 SHALL wrap modulo 2^BITS in s; carry beyond BITS appears only on co.

Reset
REQ-020 SHALL, on rst asserted, asynchronously clear all valid bits, s, co, ovf and all internal data/carry registers to 0.
REQ-021 SHALL discard all in-flight beats on rst mid-operation; first output after release belongs to a beat accepted after release.
REQ-022 SHALL drive in_ready = 1 during and immediately after reset (out_valid = 0).

Verification (BITS=32, STAGES=4 unless noted)
REQ-023 SHALL cover add: a=0xFFFFFFFF, b=0x00000001, ci=0, sub=0 -> 4 cycles later s=0x00000000, co=1, ovf=0.
REQ-024 SHALL cover sub overflow: a=0x80000000, b=0x00000001, sub=1 -> s=0x7FFFFFFF, co=1, ovf=1; and a=0x00000005, b=0x00000007, sub=1 -> s=0xFFFFFFFE, co=0, ovf=0.
REQ-025 SHALL cover full-rate stream of 8 beats with out_ready=1 -> 8 results in consecutive cycles, in order, first at cycle 4 after first accept.
REQ-026 SHALL cover backpressure: out_ready=0 for 3 cycles while pipe full -> in_ready=0, outputs stable, no loss; release -> remaining beats drain in order.
REQ-027 SHALL cover rst asserted with 3 beats in flight -> out_valid=0, s=0 immediately; no stale beat emerges after release.
REQ-028 SHALL cover STAGES=1 and STAGES=32 builds with random a, b, ci, sub against a reference model, 10000 beats each, with random out_ready.
